// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: FSM state encoding
// (3-bit) and the error codes reported on err_code.
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CSUM = 2'b10;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// imem_loader_byte_packer
// Packs a little-endian byte stream into 32-bit words: byte lane 0 lands in
// bits [7:0], lane 3 in bits [31:24]. When the fourth byte of a word is
// accepted, the complete word is registered and o_word_valid pulses for
// exactly one cycle.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_clear        restart at lane 0 (beginning of a new load)
//   i_byte_valid   a payload byte is accepted this cycle
//   i_byte         payload byte
//   o_last_lane    the byte accepted this cycle completes a word
//   o_word_valid   registered one-cycle strobe for o_word
//   o_word         packed word {b3,b2,b1,b0}
// -----------------------------------------------------------------------------
module imem_loader_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_last_lane,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_lane;
  logic [23:0] r_acc;
  logic        r_word_valid;
  logic [31:0] r_word;

  assign o_last_lane  = (r_lane == 2'd3);
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values; blocking = here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane       <= 2'd0;
      r_acc        <= 24'd0;
      r_word_valid <= 1'b0;
      r_word       <= 32'd0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_lane <= 2'd0;
        r_acc  <= 24'd0;
      end else if (i_byte_valid) begin
        case (r_lane)
          2'd0: r_acc[7:0]   <= i_byte;
          2'd1: r_acc[15:8]  <= i_byte;
          2'd2: r_acc[23:16] <= i_byte;
          default: begin
            r_word       <= {i_byte, r_acc};
            r_word_valid <= 1'b1;
          end
        endcase
        r_lane <= r_lane + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Host-side writer for the CPU instruction memory. Receives a length-prefixed
// (16-bit N, little-endian) byte stream, packs 4*N payload bytes into N words
// written to word addresses 0..N-1, and holds the CPU in reset until a
// complete, valid program has been loaded.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to append a one-byte XOR
// checksum of the payload after the data; a mismatch aborts with err_code=10.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          one-cycle pulse, begins a new load (ignored mid-load)
//   s_valid/s_data/s_ready   host byte stream handshake
//   imem_we/imem_addr/imem_wdata   registered instruction-memory write port
//   cpu_rst        active-high CPU core reset, low only after a good load
//   busy           load in progress
//   done/error     sticky result of the last load
//   err_code       01 length > DEPTH, 10 checksum mismatch, 00 none
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code
);

  state_t              r_state;
  state_t              w_next_state;
  logic [15:0]         r_len;
  logic [ADDR_W:0]     r_word_cnt;  // one extra bit so N = DEPTH does not wrap
  logic [ADDR_W-1:0]   r_imem_addr;
  logic [1:0]          r_err_code;

  logic                w_accept;
  logic                w_start_ok;
  logic [15:0]         w_len_full;
  logic                w_len_too_big;
  logic                w_len_zero;
  logic                w_data_byte;
  logic                w_last_lane;
  logic                w_last_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t PAYLOAD_END = ST_CHK;
  logic [7:0]          r_csum;
  logic                w_csum_ok;
  assign w_csum_ok = (s_data == r_csum);
`else
  localparam state_t PAYLOAD_END = ST_DONE;
`endif

  assign w_accept      = s_valid && s_ready;
  assign w_start_ok    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERR));
  // Full length as it will be once the LEN1 byte lands this cycle.
  assign w_len_full    = {s_data, r_len[7:0]};
  assign w_len_too_big = {1'b0, w_len_full} > 17'(DEPTH);
  assign w_len_zero    = (w_len_full == 16'd0);
  assign w_data_byte   = w_accept && (r_state == ST_DATA);
  assign w_last_word   = w_data_byte && w_last_lane &&
                         ((17'(r_word_cnt) + 17'd1) == {1'b0, r_len});

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (w_start_ok),
    .i_byte_valid (w_data_byte),
    .i_byte       (s_data),
    .o_last_lane  (w_last_lane),
    .o_word_valid (imem_we),
    .o_word       (imem_wdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) w_next_state = ST_LEN0;
      end
      ST_LEN0: begin
        if (w_accept) w_next_state = ST_LEN1;
      end
      ST_LEN1: begin
        if (w_accept) begin
          if (w_len_too_big)   w_next_state = ST_ERR;
          else if (w_len_zero) w_next_state = PAYLOAD_END;
          else                 w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_last_word) w_next_state = PAYLOAD_END;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (w_accept) w_next_state = w_csum_ok ? ST_DONE : ST_ERR;
      end
`endif
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state; done/error are sticky because
  // DONE and ERR are only left through a new start.
  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    cpu_rst = 1'b1;
    done    = 1'b0;
    error   = 1'b0;
    case (r_state)
      ST_LEN0, ST_LEN1, ST_DATA, ST_CHK: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
      ST_DONE: begin
        cpu_rst = 1'b0;
        done    = 1'b1;
      end
      ST_ERR:  error = 1'b1;
      default: ;
    endcase
  end

  // Datapath: length, word address, error code. The instruction memory itself
  // lives outside this block and is never cleared; aborted loads leave their
  // partial writes behind while the CPU stays in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len       <= 16'd0;
      r_word_cnt  <= '0;
      r_imem_addr <= '0;
      r_err_code  <= ERR_NONE;
    end else if (w_start_ok) begin
      r_len      <= 16'd0;
      r_word_cnt <= '0;
      r_err_code <= ERR_NONE;
    end else if (w_accept) begin
      case (r_state)
        ST_LEN0: r_len[7:0] <= s_data;
        ST_LEN1: begin
          r_len[15:8] <= s_data;
          if (w_len_too_big) r_err_code <= ERR_LEN;
        end
        ST_DATA: begin
          if (w_last_lane) begin
            r_imem_addr <= r_word_cnt[ADDR_W-1:0];
            r_word_cnt  <= r_word_cnt + {{ADDR_W{1'b0}}, 1'b1};
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (!w_csum_ok) r_err_code <= ERR_CSUM;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_csum <= 8'd0;
    else if (w_start_ok)  r_csum <= 8'd0;
    else if (w_data_byte) r_csum <= r_csum ^ s_data;
  end
`endif

  assign imem_addr = r_imem_addr;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Scoreboard bench for imem_loader. Each load is described as a byte list;
// the reference model decodes the length prefix, forms words arithmetically
// and queues the expected writes. A monitor pops and compares on each write
// strobe. Defining IMEM_LOADER_CHECKSUM_EN also exercises the checksum byte.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'd0;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              error;
  logic [1:0]        err_code;

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    bit                last;
  } wr_t;
  typedef logic [7:0] bq_t[$];

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  we_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      we_count++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(e.addr));
        check("write_data", imem_wdata, e.data);
        if (e.last) begin
          check("done_at_last_write", 32'(done), 32'd1);
          check("cpu_rst_at_last_write", 32'(cpu_rst), 32'd0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_rst"},  32'(cpu_rst),  32'd1);
    check({tag, "_s_ready"},  32'(s_ready),  32'd0);
    check({tag, "_imem_we"},  32'(imem_we),  32'd0);
    check({tag, "_addr"},     32'(imem_addr), 32'd0);
    check({tag, "_wdata"},    imem_wdata,    32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_error"},    32'(error),    32'd0);
    check({tag, "_err_code"}, 32'(err_code), 32'd0);
  endtask

  // Start pulse; s_valid may be held high with a junk byte that must not
  // be consumed.
  task automatic pulse_start(input bit junk_valid);
    s_valid = junk_valid;
    s_data  = 8'hA5;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    s_valid = 1'b0;
  endtask

  // Offer one byte until accepted; returns at edge+1 of the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gapped, inout int cycles);
    bit ok;
    ok = 1'b0;
    if (gapped) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data  = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
      cycles++;
      if (ok) break;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got s_ready=0 for 50 cycles, expected acceptance");
    end
    s_valid = 1'b0;
  endtask

  // Full load: model computes expected writes and final status.
  task automatic run_load(input bq_t b, input bit gapped, input bit ovr_en, input logic [7:0] ovr);
    int         n;
    bit         len_err;
    logic [7:0] csum;
    logic [7:0] sent_csum;
    bit         csum_fail;
    bq_t        tx;
    int         cycles;
    wr_t        w;
    n       = int'(b[0]) + 256 * int'(b[1]);
    len_err = (n > DEPTH);
    csum    = 8'd0;
    tx.push_back(b[0]);
    tx.push_back(b[1]);
    if (!len_err) begin
      for (int k = 0; k < n; k++) begin
        w.addr = ADDR_W'(k);
        w.data = 32'(b[2+4*k]) + (32'(b[3+4*k]) << 8) +
                 (32'(b[4+4*k]) << 16) + (32'(b[5+4*k]) << 24);
        w.last = (k == n - 1) && !CSUM;
        exp_q.push_back(w);
        for (int j = 0; j < 4; j++) begin
          csum = csum ^ b[2+4*k+j];
          tx.push_back(b[2+4*k+j]);
        end
      end
    end
    sent_csum = ovr_en ? ovr : csum;
    csum_fail = CSUM && !len_err && (sent_csum != csum);
    if (CSUM && !len_err) tx.push_back(sent_csum);

    we_count = 0;
    pulse_start(gapped);
    check("start_busy",     32'(busy),     32'd1);
    check("start_s_ready",  32'(s_ready),  32'd1);
    check("start_done_clr", 32'(done),     32'd0);
    check("start_err_clr",  32'({error, err_code}), 32'd0);
    check("start_cpu_rst",  32'(cpu_rst),  32'd1);

    cycles = 0;
    for (int i = 0; i < tx.size(); i++) send_byte(tx[i], gapped, cycles);

    // Cycle after the final accepting edge.
    check("end_busy",    32'(busy),    32'd0);
    check("end_s_ready", 32'(s_ready), 32'd0);
    if (len_err) begin
      check("len_err_error",    32'(error),    32'd1);
      check("len_err_code",     32'(err_code), 32'd1);
      check("len_err_cpu_rst",  32'(cpu_rst),  32'd1);
      check("len_err_done",     32'(done),     32'd0);
    end else if (csum_fail) begin
      check("csum_err_error",   32'(error),    32'd1);
      check("csum_err_code",    32'(err_code), 32'd2);
      check("csum_err_cpu_rst", 32'(cpu_rst),  32'd1);
    end else begin
      check("ok_done",     32'(done),     32'd1);
      check("ok_cpu_rst",  32'(cpu_rst),  32'd0);
      check("ok_error",    32'({error, err_code}), 32'd0);
    end
    if (!gapped) check("no_stall_cycles", 32'(cycles), 32'(tx.size()));

    repeat (3) begin @(posedge clk); #1; end
    check("writes_per_load", 32'(we_count), len_err ? 32'd0 : 32'(n));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  function automatic bq_t rand_load(input int n);
    bq_t q;
    q.push_back(8'(n));
    q.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom_range(0, 255)));
    return q;
  endfunction

  initial begin
    bq_t q;
    int  cyc;

    // Reset, then idle with s_valid asserted: nothing happens.
    #12;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h55;
    repeat (5) begin
      @(negedge clk);
      check("idle_s_ready", 32'(s_ready), 32'd0);
      check("idle_cpu_rst", 32'(cpu_rst), 32'd1);
      check("idle_done",    32'(done),    32'd0);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
    check("idle_no_writes", 32'(we_count), 32'd0);

    // Directed two-word program, back-to-back then every other cycle.
    q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(q, 1'b0, 1'b0, 8'h00);
    run_load(q, 1'b1, 1'b0, 8'h00);

    // Length overflow N = 257.
    q = '{8'h01, 8'h01};
    run_load(q, 1'b0, 1'b0, 8'h00);

    // Empty program and full-depth program.
    run_load(rand_load(0), 1'b0, 1'b0, 8'h00);
    run_load(rand_load(DEPTH), 1'b0, 1'b0, 8'h00);

    // Abort after 6 data bytes: word 0 is written, rest is discarded.
    w_push(8'd0, 32'h44332211);
    pulse_start(1'b0);
    q = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    cyc = 0;
    for (int i = 0; i < q.size(); i++) send_byte(q[i], 1'b0, cyc);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("abort6");
    check("abort6_scoreboard", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(q, 1'b0, 1'b0, 8'h00);

    // Reset in the cycle of a pending write strobe: strobe must vanish.
    pulse_start(1'b0);
    q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    cyc = 0;
    for (int i = 0; i < q.size(); i++) send_byte(q[i], 1'b0, cyc);
    rst_n = 1'b0;
    #1 check_reset_outputs("abort_we");
    @(posedge clk); #1 rst_n = 1'b1;
    q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(q, 1'b1, 1'b0, 8'h00);

`ifdef IMEM_LOADER_CHECKSUM_EN
    q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(q, 1'b0, 1'b1, 8'h22);
    run_load(q, 1'b0, 1'b1, 8'h00);
`endif

    // Randomized loads.
    for (int r = 0; r < 12; r++) begin
      bit gap;
      bit bad;
      gap = 1'($urandom_range(0, 1));
      bad = CSUM && ($urandom_range(0, 3) == 0);
      run_load(rand_load($urandom_range(0, 6)), gap, bad, 8'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic w_push(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.last = 1'b0;
    exp_q.push_back(w);
  endtask

endmodule

// File: doc/imem_loader.md
# imem_loader

Host-side writer for the CPU's instruction memory. Accepts a length-prefixed little-endian byte stream over a valid/ready handshake, packs bytes into 32-bit instruction words, and writes them to consecutive instruction-memory word addresses. Holds the CPU in reset until a complete, valid program is loaded, then releases it.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory word-address width
- DEPTH, 256, instruction-memory capacity in words; must be ≤ 2^ADDR_W

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a new load
- s_valid  in  1  host byte valid
- s_data  in  8  host byte
- s_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  instruction word
- cpu_rst  out  1  active-high reset to the CPU core (pc, regfile)
- busy  out  1  load in progress
- done  out  1  sticky; last load completed successfully
- error  out  1  sticky; last load aborted
- err_code  out  2  01 = length exceeds DEPTH, 10 = checksum mismatch, 00 = none

## Operation
- States: IDLE, LEN0, LEN1, DATA, CHK (macro only), DONE, ERR.
- Reset: state IDLE, cpu_rst=1, s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, error=0, err_code=00.
- start in IDLE/DONE/ERR -> LEN0; clears done, error, err_code, byte/word counters; cpu_rst=1. start in LEN0/LEN1/DATA/CHK ignored.
- Byte transfer = s_valid && s_ready at a rising edge. s_ready=1 only in LEN0, LEN1, DATA, CHK.
- LEN0 takes N[7:0]; LEN1 takes N[15:8].
- After LEN1: N > DEPTH -> ERR, err_code=01. N = 0 -> DONE (or CHK). Otherwise -> DATA.
- DATA: bytes b0..b3 form word {b3,b2,b1,b0}. On the 4th byte, write word k (k = 0..N-1) to imem_addr=k.
- After word N-1: -> DONE (or CHK).
- DONE: cpu_rst=0, done=1. ERR: cpu_rst=1, error=1.
- busy=1 in LEN0, LEN1, DATA, CHK.
- Instruction-memory contents are never cleared. Partial writes from aborted loads remain in memory, but the CPU stays in reset.

## Timing
- Byte throughput: 1 byte per cycle sustained; no internal stall in DATA.
- imem_we is registered: 4th byte accepted at edge E -> imem_we=1 for exactly the cycle after E, with imem_addr/imem_wdata valid in that same cycle.
- Final word accepted at edge E -> state DONE at E. cpu_rst falls and done rises in the cycle after E, which is the same cycle as the final imem_we pulse. The CPU's first clock edge out of reset commits after the write.
- Length error: LEN1 byte accepted at edge E -> ERR, error=1, s_ready=0 from the cycle after E.
- s_valid in IDLE/DONE/ERR: ignored, not consumed.
- start coincident with s_valid: the byte is not consumed that cycle.
- Reset asserted mid-load: all outputs return to reset values immediately (asynchronous). Any pending imem_we is dropped.
- N = DEPTH is legal; last address is DEPTH-1.
- Word counter is ADDR_W+1 bits wide so N = DEPTH does not wrap.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: after the last data byte (or after LEN1 when N=0), enter CHK and take one byte. The expected byte is the XOR of all 4·N payload bytes, seeded 0x00; length bytes are excluded. Match -> DONE. Mismatch -> ERR with err_code=10. In both cases the next state takes effect at the checksum edge and done/error assert in the following cycle. All payload words are still written before the check.
- Not defined: no CHK state, no checksum logic, and err_code=10 never occurs.

## Structure
- Shared header loader_defs.vh holds:
  - state encodings (3-bit)
  - err_code constants ERR_NONE, ERR_LEN, ERR_CSUM
- One natural sub-module, byte_packer:
  - 2-bit byte lane counter and 32-bit shift/assemble register
  - emits a one-cycle word_valid with the packed word
- imem_loader owns the FSM, length register, word address counter, checksum and status flags.

## Test plan
- Reset, no start -> cpu_rst=1, s_ready=0, done=0, no imem_we; bytes on s_valid are not consumed.
- start; stream 02 00 13 00 00 00 93 00 10 00 -> writes addr0=0x00000013, addr1=0x00100093; done=1, cpu_rst=0 in the cycle of the second write.
- start; length bytes 01 01 (N=257, DEPTH=256) -> ERR, err_code=01, cpu_rst=1, no imem_we, s_ready=0.
- Back-to-back valid bytes, then s_valid toggled every other cycle -> identical writes; exactly one imem_we per 4 accepted bytes.
- Reset pulse after 6 data bytes, then a fresh load of N=1 word 0xDEADBEEF -> addr0=0xDEADBEEF, done=1; no leftover bytes from the aborted load are packed.
- With IMEM_LOADER_CHECKSUM_EN: N=1, bytes EF BE AD DE, checksum 0x22 -> DONE. Repeating with checksum 0x00 -> ERR, err_code=10, and the word is still written.
